// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that hands one shared FIFO write port to one of NUM_REQ
// requesters for bursts of up to MAX_BURST beats, stalling on fifo_full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = IDX_W + 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [IDX_W-1:0] LAST_REQ  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [SUM_W-1:0] NUM_REQ_S = SUM_W'(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic               busy_nxt;

    logic [2*NUM_REQ-1:0] req_rot;
    logic [IDX_W-1:0]     sel_off, sel_idx;
    logic [SUM_W-1:0]     sel_sum;
    logic                 sel_vld;
    logic                 owner_req, beat, release_gnt;

    // Rotate so rr_ptr lands at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        req_rot = {req, req} >> rr_ptr;
        sel_vld = |req;
        sel_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) sel_off = IDX_W'(k);
        end
        sel_sum = {1'b0, rr_ptr} + {1'b0, sel_off};
        if (sel_sum >= NUM_REQ_S)
            sel_idx = IDX_W'(sel_sum - NUM_REQ_S);
        else
            sel_idx = sel_sum[IDX_W-1:0];
    end

    // rst gates the beat so a reset cycle mid-burst never writes.
    always_comb begin
        owner_req   = req[owner];
        beat        = (state == GRANT) && owner_req && !fifo_full && !rst;
        release_gnt = (state == GRANT) &&
                      (!owner_req || (beat && (beat_cnt == LAST_BEAT)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            gnt      <= gnt_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        gnt_nxt      = gnt;
        busy_nxt     = busy;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    state_nxt    = GRANT;
                    owner_nxt    = sel_idx;
                    beat_cnt_nxt = '0;
                    gnt_nxt      = NUM_REQ'(1) << sel_idx;
                    busy_nxt     = 1'b1;
                end
            end
            GRANT: begin
                if (release_gnt) begin
                    state_nxt    = IDLE;
                    gnt_nxt      = '0;
                    busy_nxt     = 1'b0;
                    beat_cnt_nxt = '0;
                    rr_ptr_nxt   = (owner == LAST_REQ) ? '0 : owner + IDX_W'(1);
                end else if (beat) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_comb begin
        fifo_wr_en = beat;
        req_ack    = '0;
        if (beat) req_ack[owner] = 1'b1;
        if (state == GRANT)
            fifo_din = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
        else
            fifo_din = '0;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: each scenario queues the words it expects on the FIFO port;
// a negedge monitor pops and compares every write.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic                          busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_WIDTH-1:0] sb[$];

    fifo_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
        .gnt(gnt), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_WIDTH-1:0] word(input int i);
        return DATA_WIDTH'(8'hA0 + i);
    endfunction

    task automatic push(input int i, input int n);
        for (int k = 0; k < n; k++) sb.push_back(word(i));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (fifo_full) chk("wr_while_full", 32'(fifo_wr_en), 0);
        if (fifo_wr_en === 1'b1) begin
            chk("ack_vs_gnt", 32'(req_ack), 32'(gnt));
            if (sb.size() == 0) chk("sb_extra_write", sb.size(), 1);
            else                chk("din", 32'(fifo_din), 32'(sb.pop_front()));
        end
    end

    initial begin
        int order[5];
        order = '{0, 1, 2, 3, 0};
        rst = 1'b1; req = '0; fifo_full = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_WIDTH +: DATA_WIDTH] = word(i);
        repeat (2) tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr", 32'(fifo_wr_en), 0);
        chk("rst_ack", 32'(req_ack), 0);
        chk("rst_din", 32'(fifo_din), 0);

        // single requester 2, two back-to-back bursts
        rst = 1'b0; req = 4'b0100; push(2, 8);
        tick();
        chk("s1_gnt", 32'(gnt), 32'h4);
        chk("s1_busy", 32'(busy), 1);
        chk("s1_ack", 32'(req_ack), 32'h4);
        repeat (3) begin tick(); chk("s1_beat", 32'(fifo_wr_en), 1); end
        tick();
        chk("s1_idle_gnt", 32'(gnt), 0);
        chk("s1_idle_busy", 32'(busy), 0);
        chk("s1_idle_wr", 32'(fifo_wr_en), 0);
        chk("s1_idle_din", 32'(fifo_din), 0);
        tick();
        chk("s1_regnt", 32'(gnt), 32'h4);
        repeat (3) begin tick(); chk("s1_beat2", 32'(fifo_wr_en), 1); end
        tick();
        chk("s1_idle2", 32'(gnt), 0);
        req = '0;
        tick();
        chk("s1_quiet", 32'(gnt), 0);

        // all requesting: 0,1,2,3,0 with full bursts and one idle between
        do_reset();
        req = 4'b1111;
        foreach (order[g]) push(order[g], MAX_BURST);
        foreach (order[g]) begin
            tick();
            chk("s2_gnt", 32'(gnt), 32'(1) << order[g]);
            chk("s2_wr", 32'(fifo_wr_en), 1);
            repeat (3) begin tick(); chk("s2_beat", 32'(fifo_wr_en), 1); end
            tick();
            chk("s2_idle_gnt", 32'(gnt), 0);
            chk("s2_idle_wr", 32'(fifo_wr_en), 0);
        end
        req = '0;
        tick();

        // 3-cycle stall after beat 2
        do_reset();
        req = 4'b0001; push(0, 4);
        tick(); chk("s3_gnt", 32'(gnt), 32'h1);
        tick(); chk("s3_beat2", 32'(fifo_wr_en), 1);
        for (int i = 0; i < 3; i++) begin
            tick(); fifo_full = 1'b1; #1;
            chk("s3_stall_wr", 32'(fifo_wr_en), 0);
            chk("s3_stall_ack", 32'(req_ack), 0);
            chk("s3_stall_gnt", 32'(gnt), 32'h1);
        end
        tick(); fifo_full = 1'b0; #1;
        chk("s3_beat3", 32'(fifo_wr_en), 1);
        tick(); chk("s3_beat4", 32'(fifo_wr_en), 1);
        tick(); chk("s3_rel", 32'(gnt), 0);
        req = '0;

        // owner 1 drops after 2 beats; others change under it
        do_reset();
        req = 4'b0010; push(1, 2); push(3, 4); push(0, 4);
        tick(); chk("s4_gnt1", 32'(gnt), 32'h2);
        req = 4'b1011;
        tick(); chk("s4_gnt_hold", 32'(gnt), 32'h2);
        tick(); req = 4'b1001; #1;
        chk("s4_drop_wr", 32'(fifo_wr_en), 0);
        chk("s4_drop_gnt", 32'(gnt), 32'h2);
        tick(); chk("s4_idle", 32'(gnt), 0);
        tick(); chk("s4_gnt3", 32'(gnt), 32'h8);
        repeat (3) tick();
        tick(); chk("s4_idle2", 32'(gnt), 0);
        tick(); chk("s4_gnt0", 32'(gnt), 32'h1);
        repeat (3) tick();
        tick(); req = '0;

        // reset mid-burst of requester 3
        do_reset();
        req = 4'b1000; push(3, 1);
        tick(); chk("s5_gnt3", 32'(gnt), 32'h8);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        chk("s5_gnt", 32'(gnt), 0);
        chk("s5_busy", 32'(busy), 0);
        chk("s5_wr", 32'(fifo_wr_en), 0);
        req = 4'b1111; push(0, 4);
        tick(); chk("s5_first", 32'(gnt), 32'h1);
        repeat (3) tick();
        tick(); req = '0;

        // FIFO full held: grant sits, no writes, resumes same cycle it clears
        do_reset();
        fifo_full = 1'b1; req = 4'b0010; push(1, 4);
        tick(); chk("s6_gnt", 32'(gnt), 32'h2);
        repeat (6) begin
            tick();
            chk("s6_hold", 32'(gnt), 32'h2);
            chk("s6_nowr", 32'(fifo_wr_en), 0);
        end
        tick(); fifo_full = 1'b0; #1;
        chk("s6_resume", 32'(fifo_wr_en), 1);
        repeat (3) tick();
        tick(); chk("s6_rel", 32'(gnt), 0);
        req = '0;
        repeat (2) tick();

        chk("sb_left", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
- REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..16.
- REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: width of one write word, matching the shared FIFO din width.
- REQ-003 The block SHALL have parameter MAX_BURST, default 4: maximum beats per grant, legal range 1..256.
- REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates on posedge.
- REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
- REQ-006 The block SHALL have port req, input, NUM_REQ bits: request per requester, level-sensitive.
- REQ-007 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- REQ-008 The block SHALL have port req_ack, output, NUM_REQ bits: combinational; a word from requester i is consumed this cycle.
- REQ-009 The block SHALL have port gnt, output, NUM_REQ bits: registered, one-hot or zero; current owner of the FIFO write port.
- REQ-010 The block SHALL have port fifo_full, input, 1 bit: full flag from the shared FIFO.
- REQ-011 The block SHALL have port fifo_wr_en, output, 1 bit: combinational write enable to the shared FIFO.
- REQ-012 The block SHALL have port fifo_din, output, DATA_WIDTH bits: combinational write data to the shared FIFO.
- REQ-013 The block SHALL have port busy, output, 1 bit: registered; high while in state GRANT.

Function
- REQ-014 The FSM SHALL have two states: IDLE (gnt=0) and GRANT (gnt one-hot).
- REQ-015 In IDLE with req nonzero, the block SHALL select the first asserted requester searching from rr_ptr upward modulo NUM_REQ.
- REQ-016 On that selection, the block SHALL set gnt to the selected requester and enter GRANT on the next edge, with beat_cnt=0; req-to-gnt latency is 1 cycle.
- REQ-017 A beat SHALL occur in a cycle when state=GRANT, req[owner]=1 and fifo_full=0.
- REQ-018 On a beat: fifo_wr_en=1, fifo_din=req_data[owner], req_ack[owner]=1, all other req_ack bits=0.
- REQ-019 With no beat: fifo_wr_en=0, req_ack=0, and fifo_din = req_data[owner], or 0 in IDLE.
- REQ-020 beat_cnt SHALL increment by 1 per beat and SHALL be sized to hold MAX_BURST-1.
- REQ-021 fifo_full=1 SHALL stall only: grant held, no beat, beat_cnt unchanged, no timeout.
- REQ-022 Release SHALL occur when a beat happens with beat_cnt=MAX_BURST-1, or when req[owner]=0 in GRANT (no beat that cycle).
- REQ-023 On release, next edge: gnt=0, state=IDLE, rr_ptr=(owner+1) mod NUM_REQ; exactly one IDLE cycle separates consecutive grants.
- REQ-024 Requests changing on non-owner lines during GRANT SHALL have no effect until the next arbitration.
- REQ-025 No write SHALL ever be issued while fifo_full=1, and at most one requester SHALL be acked per cycle.

Reset
- REQ-026 While rst=1 at a clock edge: state=IDLE, gnt=0, busy=0, rr_ptr=0, beat_cnt=0; consequently fifo_wr_en=0 and req_ack=0 from the next cycle.
- REQ-027 rst SHALL take priority over all other inputs, including mid-burst; the partial burst is abandoned and no further beats are issued.

Verification
- REQ-028 Bench SHALL cover: NUM_REQ=4, MAX_BURST=4, req=0100 held, fifo_full=0 -> gnt=0100 one cycle after req; 4 consecutive writes of req_data[2]; 1 idle cycle; regrant to 2; pattern repeats.
- REQ-029 Bench SHALL cover: req=1111 held -> grant order 0,1,2,3,0; each grant exactly 4 beats; 1 idle cycle between grants.
- REQ-030 Bench SHALL cover: fifo_full=1 for 3 cycles after beat 2 -> fifo_wr_en=0 and req_ack=0 during the stall; gnt held; burst resumes and totals exactly 4 beats.
- REQ-031 Bench SHALL cover: owner 1 drops req after 2 beats, req=1001 otherwise -> release; rr_ptr=2; next grant to requester 3, then requester 0.
- REQ-032 Bench SHALL cover: rst pulsed after beat 1 of a grant to 3 -> next cycle gnt=0, busy=0, fifo_wr_en=0; with req=1111 after reset, first grant to requester 0.
- REQ-033 Bench SHALL cover: fifo_full=1 held with req=0010 -> gnt=0010 indefinitely, zero writes; on fifo_full falling, writes resume in the same cycle.
